// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: control-bundle field positions, default width, stage keep masks and NOP.
package ctrl_pipe_pkg;
  localparam int CTRL_W_DEF = 13;
  localparam int OPC_HI = 12;
  localparam int OPC_LO = 9;
  localparam int AM_B = 8;
  localparam int S_B = 7;
  localparam int LOAD_B = 6;
  localparam int RF_B = 5;
  localparam int SIZE_B = 4;
  localparam int RW_B = 3;
  localparam int EN_B = 2;
  localparam int BL_B = 1;
  localparam int B_B = 0;
  localparam logic [CTRL_W_DEF-1:0] KEEP_EX = 13'h1FFF;
  localparam logic [CTRL_W_DEF-1:0] KEEP_MEM = 13'h007C;
  localparam logic [CTRL_W_DEF-1:0] KEEP_WB = 13'h0020;
  localparam logic [CTRL_W_DEF-1:0] NOP = 13'h0000;
endpackage

// File: rtl/ctrl_stage_reg.sv
// ctrl_stage_reg: one {valid, ctrl} pipeline register with load enable, kill and field mask.
module ctrl_stage_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int W = CTRL_W_DEF,
  parameter logic [W-1:0] KEEP = '1
) (
  input  logic         clk,
  input  logic         R,
  input  logic         le,
  input  logic         kill,
  input  logic         d_valid,
  input  logic [W-1:0] d_ctrl,
  output logic         q_valid,
  output logic [W-1:0] q_ctrl
);
  logic live;
  assign live = d_valid && !kill;
  // an invalid slot always carries all-zero ctrl
  always_ff @(posedge clk or negedge R)
    if (!R) begin
      q_valid <= 1'b0;
      q_ctrl <= '0;
    end else if (le) begin
      q_valid <= live;
      q_ctrl <= live ? d_ctrl & KEEP : '0;
    end
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: STAGES-deep masked control pipeline with stall, bubble and flush.
// Macro CTRL_PIPE_PERF_EN builds the saturating bubble counter; otherwise bubble_cnt is 0.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int STAGES = 3,
  parameter logic [STAGES*CTRL_W-1:0] KEEP_MASK = {KEEP_WB, KEEP_MEM, KEEP_EX},
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     R,
  input  logic                     LE,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic                     in_valid,
  input  logic                     bubble,
  input  logic                     flush,
  output logic [STAGES*CTRL_W-1:0] out_ctrl,
  output logic [STAGES-1:0]        out_valid,
  output logic [CNT_W-1:0]         bubble_cnt
);
  if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > STAGES) begin : g_bad_flush
    $error("ctrl_pipe: FLUSH_DEPTH must be within 1..STAGES");
  end
  logic [STAGES:0] v_chain;
  logic [(STAGES+1)*CTRL_W-1:0] c_chain;
  assign v_chain[0] = in_valid;
  assign c_chain[CTRL_W-1:0] = in_ctrl;
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    // flush outranks bubble; bubble only ever empties stage 0
    ctrl_stage_reg #(.W(CTRL_W), .KEEP(KEEP_MASK[s*CTRL_W +: CTRL_W])) u_stage (
      .clk(clk),
      .R(R),
      .le(LE),
      .kill((flush && s < FLUSH_DEPTH) || (bubble && s == 0)),
      .d_valid(v_chain[s]),
      .d_ctrl(c_chain[s*CTRL_W +: CTRL_W]),
      .q_valid(v_chain[s+1]),
      .q_ctrl(c_chain[(s+1)*CTRL_W +: CTRL_W])
    );
  end
  assign out_valid = v_chain[STAGES:1];
  assign out_ctrl = c_chain[(STAGES+1)*CTRL_W-1:CTRL_W];
`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge R)
    if (!R) cnt <= '0;
    else if (LE && bubble && !flush && cnt != '1) cnt <= cnt + 1'b1;
  assign bubble_cnt = cnt;
`else
  assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: table-driven check of latency, masking, bubble, stall and flush plus reset/saturation sequences.
`timescale 1ns/100ps
module tb_ctrl_pipe;
  localparam bit PERF =
`ifdef CTRL_PIPE_PERF_EN
    1'b1;
`else
    1'b0;
`endif
  logic clk = 1'b0;
  logic R, LE, in_valid, bubble, flush;
  logic [12:0] in_ctrl;
  logic [38:0] oc_a, oc_b;
  logic [2:0] ov_a, ov_b;
  logic [15:0] cnt_a;
  logic [3:0] cnt_b;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  ctrl_pipe u_a (
    .clk(clk), .R(R), .LE(LE), .in_ctrl(in_ctrl), .in_valid(in_valid), .bubble(bubble),
    .flush(flush), .out_ctrl(oc_a), .out_valid(ov_a), .bubble_cnt(cnt_a)
  );
  ctrl_pipe #(.FLUSH_DEPTH(2), .CNT_W(4)) u_b (
    .clk(clk), .R(R), .LE(LE), .in_ctrl(in_ctrl), .in_valid(in_valid), .bubble(bubble),
    .flush(flush), .out_ctrl(oc_b), .out_valid(ov_b), .bubble_cnt(cnt_b)
  );
  typedef struct {
    logic le, vin, bub, fl;
    logic [12:0] ctrl;
    logic [38:0] ec;
    logic [2:0] ev;
  } vec_t;
  vec_t tv[14];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic le, vin, bub, fl, input logic [12:0] c);
    LE = le;
    in_valid = vin;
    bubble = bub;
    flush = fl;
    in_ctrl = c;
  endtask
  initial begin
    tv[0]  = '{1, 1, 0, 0, 13'h1A65, {13'h0000, 13'h0000, 13'h1A65}, 3'b001};
    tv[1]  = '{1, 0, 0, 0, 13'h1FFF, {13'h0000, 13'h0064, 13'h0000}, 3'b010};
    tv[2]  = '{1, 0, 0, 0, 13'h0000, {13'h0020, 13'h0000, 13'h0000}, 3'b100};
    tv[3]  = '{1, 0, 0, 0, 13'h0000, {13'h0000, 13'h0000, 13'h0000}, 3'b000};
    tv[4]  = '{1, 1, 0, 0, 13'h1555, {13'h0000, 13'h0000, 13'h1555}, 3'b001};
    tv[5]  = '{1, 1, 1, 0, 13'h0ABC, {13'h0000, 13'h0054, 13'h0000}, 3'b010};
    tv[6]  = '{1, 1, 0, 0, 13'h1234, {13'h0000, 13'h0000, 13'h1234}, 3'b101};
    tv[7]  = '{1, 1, 0, 0, 13'h1FFF, {13'h0000, 13'h0034, 13'h1FFF}, 3'b011};
    tv[8]  = '{1, 1, 0, 0, 13'h0F0F, {13'h0020, 13'h007C, 13'h0F0F}, 3'b111};
    tv[9]  = '{0, 1, 1, 0, 13'h1111, {13'h0020, 13'h007C, 13'h0F0F}, 3'b111};
    tv[10] = '{0, 1, 0, 1, 13'h1111, {13'h0020, 13'h007C, 13'h0F0F}, 3'b111};
    tv[11] = '{0, 1, 1, 1, 13'h1111, {13'h0020, 13'h007C, 13'h0F0F}, 3'b111};
    tv[12] = '{0, 0, 0, 0, 13'h1111, {13'h0020, 13'h007C, 13'h0F0F}, 3'b111};
    tv[13] = '{1, 1, 1, 1, 13'h1111, {13'h0020, 13'h000C, 13'h0000}, 3'b110};
    R = 1'b1;
    drive(1, 1, 0, 0, 13'h1A65);
    #2 R = 1'b0;
    #1;
    chk("async_reset_ctrl", {25'd0, oc_a}, 64'd0);
    chk("async_reset_valid", {61'd0, ov_a}, 64'd0);
    chk("async_reset_cnt", {48'd0, cnt_a}, 64'd0);
    #5 R = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(tv[i].le, tv[i].vin, tv[i].bub, tv[i].fl, tv[i].ctrl);
      tick();
      chk($sformatf("vec%0d_ctrl", i), {25'd0, oc_a}, {25'd0, tv[i].ec});
      chk($sformatf("vec%0d_valid", i), {61'd0, ov_a}, {61'd0, tv[i].ev});
      if (i == 8 || i == 12) chk($sformatf("vec%0d_cnt", i), {48'd0, cnt_a}, PERF ? 64'd1 : 64'd0);
    end
    chk("flush2_ctrl", {25'd0, oc_b}, {25'd0, 13'h0020, 13'h0000, 13'h0000});
    chk("flush2_valid", {61'd0, ov_b}, 64'b100);
    chk("flush_bubble_cnt_a", {48'd0, cnt_a}, PERF ? 64'd1 : 64'd0);
    chk("flush_bubble_cnt_b", {60'd0, cnt_b}, PERF ? 64'd1 : 64'd0);
    drive(1, 1, 0, 0, 13'h1A65);
    repeat (3) tick();
    chk("inflight_valid", {61'd0, ov_a}, 64'b111);
    #2 R = 1'b0;
    #0.5;
    chk("midflight_reset_ctrl", {25'd0, oc_a}, 64'd0);
    chk("midflight_reset_valid", {61'd0, ov_a}, 64'd0);
    chk("midflight_reset_cnt_b", {60'd0, cnt_b}, 64'd0);
    #0.5 R = 1'b1;
    drive(1, 1, 0, 0, 13'h0ABC);
    tick();
    chk("restart_ctrl", {25'd0, oc_a}, {25'd0, 13'h0000, 13'h0000, 13'h0ABC});
    chk("restart_valid", {61'd0, ov_a}, 64'b001);
    drive(1, 1, 1, 0, 13'h0ABC);
    repeat (20) tick();
    chk("sat_cnt_b", {60'd0, cnt_b}, PERF ? 64'hF : 64'd0);
    chk("wide_cnt_a", {48'd0, cnt_a}, PERF ? 64'd20 : 64'd0);
    chk("bubble_drain_valid", {61'd0, ov_a}, 64'd0);
    tick();
    chk("sat_hold_b", {60'd0, cnt_b}, PERF ? 64'hF : 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Parametrised control-signal pipeline. It carries the decoded control bundle from the decode stage through STAGES downstream pipeline registers (default EX, MEM, WB). It replaces the fixed per-stage control registers with one generic block. Adds per-stage field masking, valid bits, bubble insertion, branch flush, global stall and optional bubble accounting.

Parameters:
CTRL_W, 13, width of the control bundle: [12:9] opcode, [8] AM, [7] S_enable, [6] load_instr, [5] RF_enable, [4] Size_enable, [3] RW_enable, [2] Enable_signal, [1] BL_instr, [0] B_instr
STAGES, 3, number of pipeline stages after decode; stage 0 = EX
KEEP_MASK, {13'h0020,13'h007C,13'h1FFF}, STAGES*CTRL_W packed; stage s bits live at [s*CTRL_W +: CTRL_W]; a bit is 1 if the field survives into that stage
FLUSH_DEPTH, 1, number of youngest stages killed by flush (1..STAGES)
CNT_W, 16, width of the bubble counter

Ports:
clk  in  1  pipeline clock, rising edge
R  in  1  reset; asynchronous, active-low
LE  in  1  global load enable; 0 freezes every stage
in_ctrl  in  CTRL_W  decoded control bundle from the decode stage
in_valid  in  1  in_ctrl is a real instruction
bubble  in  1  hazard stall: insert NOP into stage 0 this cycle
flush  in  1  taken-branch kill of the youngest FLUSH_DEPTH stages
out_ctrl  out  STAGES*CTRL_W  per-stage registered control, same packing as KEEP_MASK
out_valid  out  STAGES  per-stage valid bit
bubble_cnt  out  CNT_W  count of NOPs inserted (see Optional Feature)

Behaviour:
- Reset: R low forces all out_ctrl bits to 0, out_valid to 0 and bubble_cnt to 0 immediately, without waiting for a clock. The pipeline restarts empty on the first rising edge after R goes high. Reset mid-operation discards all in-flight bundles.
- Each stage holds a {valid, ctrl} register. The stored ctrl is always ANDed with the KEEP_MASK slice of that stage. Masked-off bits read 0.
- Latency: in_ctrl appears at stage 0 one clk after capture, and at stage s after s+1 clks, given LE stays 1 throughout.
- Per-edge priority, highest first:
  1. LE=0: every stage holds its value. bubble and flush are ignored, and the counter holds.
  2. flush=1: stages 0..FLUSH_DEPTH-1 load {0, 0}. Stages at or beyond FLUSH_DEPTH load their masked predecessor. The counter does not increment.
  3. bubble=1: stage 0 loads {0, 0} (NOP) and stages 1.. advance. The counter increments.
  4. Normal: stage 0 loads {in_valid, in_ctrl & KEEP0} and stage s loads {valid[s-1], ctrl[s-1] & KEEPs}.
- If in_valid=0, stage 0 stores ctrl = 0 regardless of in_ctrl. An invalid stage always reads all-zero ctrl.
- Simultaneous flush and bubble: flush wins. A killed slot is not counted as a bubble.
- The counter saturates at 2^CNT_W-1; it does not wrap.
- STAGES=1 is legal, and then FLUSH_DEPTH must be 1. FLUSH_DEPTH > STAGES is a parameter error, flagged by an elaboration-time $error.
- No combinational path from inputs to outputs.

Optional Feature:
Macro CTRL_PIPE_PERF_EN.
- Defined: bubble_cnt is a live saturating counter of inserted bubbles, as specified above.
- Undefined: no counter register is built and bubble_cnt is tied to 0. All other behaviour is identical.

Decomposition:
- Package ctrl_pipe_pkg holds:
  - the field index constants (OPC_HI/OPC_LO, AM_B, S_B, LOAD_B, RF_B, SIZE_B, RW_B, EN_B, BL_B, B_B)
  - CTRL_W_DEF = 13
  - the default KEEP masks: KEEP_EX 13'h1FFF, KEEP_MEM 13'h007C, KEEP_WB 13'h0020
  - the NOP constant, 13'h0000
- Sub-module ctrl_stage_reg is one stage: async active-low reset, load enable, kill, mask.
- ctrl_pipe instantiates STAGES copies of ctrl_stage_reg in a generate loop and adds the counter and priority logic.

Test Plan:
- Reset/latency: pulse R low at a mid-cycle time, then hold LE=1. Feed in_ctrl=13'h1A65 (valid) for 1 cycle, then NOPs.
  - Outputs must read 0 asynchronously while R is low.
  - Stage 0 = 13'h1A65 after 1 clk.
  - Stage 1 = 13'h0064 after 2 clks.
  - Stage 2 = 13'h0020 after 3 clks.
  - out_valid walks 001, 010, 100.
- Stall: fill all stages with distinct bundles, drive LE=0 for 4 clks while toggling bubble and flush.
  - All out_ctrl/out_valid are unchanged, and bubble_cnt is unchanged.
- Bubble: stream valid bundles A, B, C and assert bubble on the cycle B is presented.
  - Stage 0 shows A, then NOP (valid 0), then C; B is lost.
  - bubble_cnt = 1 with CTRL_PIPE_PERF_EN, 0 without.
- Flush vs. bubble: assert flush and bubble together with FLUSH_DEPTH=2.
  - Stages 0 and 1 are cleared and stage 2 receives the old stage 1.
  - bubble_cnt is unchanged.
- Reset mid-flight: with three valid bundles in flight, drop R for 1 ns between clock edges.
  - All outputs go to 0 immediately.
  - After release, the first new bundle appears only at stage 0.
- Saturation: with CNT_W=4 and the macro defined, hold bubble=1 for 20 clks.
  - bubble_cnt stops at 4'hF and stays there.
